ntt_butterfly_pipe: RTL and testbench
=====================================

Name: ntt_butterfly_pipe

Overview:
- Pipelined, parametrised modular butterfly for NTT/INTT datapaths.
- Successor to the single-output combinational INTT PE: produces both butterfly outputs, selects Cooley-Tukey (forward) or Gentleman-Sande (inverse) mode per transaction, optionally halves outputs for INTT scaling, and uses a valid/ready handshake with back-pressure.
- Sits between the coefficient RAM read port and the write-back path of the NTT engine.

Parameters:
- N, 9, coefficient width in bits; Q < 2^N.
- Q, 257, prime modulus.
- TAG_W, 8, width of the sideband tag (address/index) carried alongside the data.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- in_mode  in  1  0 = CT/NTT, 1 = GS/INTT.
- in_halve  in  1  1 = multiply both outputs by 2^-1 mod Q.
- in_a  in  N  operand a, in [0, Q-1].
- in_b  in  N  operand b, in [0, Q-1].
- in_w  in  N  twiddle factor, in [0, Q-1].
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_x  out  N  first butterfly output, in [0, Q-1].
- out_y  out  N  second butterfly output, in [0, Q-1].
- out_tag  out  TAG_W  tag of the transaction.

Behaviour:
- Arithmetic. Every result is fully reduced to [0, Q-1]. Subtraction wraps modulo Q, never by 2^N.
  - CT: x = a + w·b, y = a − w·b.
  - GS: x = a + b, y = (a − b)·w.
  - Halve: h(v) = v/2 if v is even, else (v+Q)/2. Computed without a multiplier.
- Inputs ≥ Q: behaviour undefined; the bench drives legal values only.
- Pipeline: 3 register stages S1, S2, S3. S3 drives the outputs. Each stage has a valid bit; mode, halve and tag travel with the data.
  - CT: S1 registers a and t = w·b mod Q. S2 registers x and y. S3 registers x and y, halved if the halve bit is set.
  - GS: S1 registers s = a+b mod Q and d = a−b mod Q. S2 registers s and d·w mod Q. S3 applies the same conditional halving.
- Latency: 3 cycles from the accept edge to out_valid when there is no stall. Throughput is 1 per cycle.
- Handshake:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - Stage k advances when its successor is empty or is itself advancing. The output stage "advances" when out_ready is high.
  - in_ready = !S1.valid | S1 advances. in_ready is combinational from out_ready and the stage valids only, never from in_valid.
  - Bubbles collapse: an empty stage accepts data even while downstream is stalled.
  - While out_valid & !out_ready, out_x, out_y and out_tag hold stable.
  - A stalled stage holds its contents. No transaction is dropped or duplicated.
  - Mixed CT/GS and halve settings back-to-back are legal with no dead cycle.
- Reset (rst_n = 0 on an edge):
  - All stage valids clear, so out_valid = 0.
  - out_x, out_y and out_tag clear to 0.
  - in_ready reads 1 from the first cycle after reset.
  - In-flight transactions are discarded. No partial result appears after rst_n deasserts.
- Ordering: results leave in acceptance order.

Decomposition:
- Shared package ntt_pkg holds:
  - default constants N_DEF = 9 and Q_DEF = 257;
  - the mode encoding (MODE_CT = 0, MODE_GS = 1);
  - the stage payload struct type {valid, mode, halve, tag, p0, p1}.
- One natural sub-module: mod_arith_unit (N, Q). It provides combinational modadd, modsub, modmul (product reduction) and modhalve.
  - It is instantiated per stage as needed, in place of the existing adder/multiplier/modred chain.
  - It is unit-tested separately.

Test Plan:
1. GS, Q=257, a=5, b=10, w=3, halve=0 → after 3 cycles x=15, y=242. Repeat with halve=1 → x=136, y=121.
2. CT, a=10, b=5, w=3 → x=25, y=252. Then a=256, b=256, w=256 → x=0, y=255 (checks wrap at Q−1).
3. Streaming: 20 random legal transactions, alternating mode every cycle, out_ready=1 → one result per cycle, in order, matching a reference model, with tags preserved.
4. Back-pressure: hold out_ready=0 for 5 cycles with continuous in_valid → in_ready drops after 3 accepts. Outputs stay stable. On release, all results arrive in order with none lost or duplicated.
5. Bubble collapse: a single transaction, then out_ready=0 with in_valid pulsing → successive transactions fill S2 and S1 while S3 is held. Counts match.
6. Reset mid-operation: 2 transactions in flight, assert rst_n=0 for 1 cycle → out_valid=0 and outputs 0 next cycle, in_ready=1, and no stale result emerges afterwards.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly datapath: default sizing, mode
// encoding, arithmetic-unit operations and the stage payload layout.
package ntt_pkg;

  localparam int N_DEF     = 9;
  localparam int Q_DEF     = 257;
  localparam int TAG_W_DEF = 8;

  typedef enum logic {
    MODE_CT = 1'b0,
    MODE_GS = 1'b1
  } mode_e;

  // Operation select for mod_arith_unit: r0/r1 pair produced per op
  typedef enum logic [1:0] {
    OP_PASS     = 2'd0,  // r0 = a,        r1 = b
    OP_ADDSUB   = 2'd1,  // r0 = a + b,    r1 = a - b
    OP_PASS_MUL = 2'd2,  // r0 = a,        r1 = b * w
    OP_HALVE    = 2'd3   // r0 = a / 2,    r1 = b / 2
  } au_op_e;

  typedef struct packed {
    logic                 valid;
    mode_e                mode;
    logic                 halve;
    logic [TAG_W_DEF-1:0] tag;
    logic [N_DEF-1:0]     p0;
    logic [N_DEF-1:0]     p1;
  } stage_t;

endpackage

// File: rtl/mod_arith_unit.sv
// Combinational modular arithmetic over Z_Q: add, subtract, multiply with
// reduction, and halving by 2^-1 mod Q, selected as an operand pair.
module mod_arith_unit
  import ntt_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] w,
  output logic [N-1:0] r0,
  output logic [N-1:0] r1
);

  localparam logic [N:0]     QE = (N+1)'(Q);
  localparam logic [2*N-1:0] QM = (2*N)'(Q);

  function automatic logic [N-1:0] modadd(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QE) s = s - QE;
    return N'(s);
  endfunction

  function automatic logic [N-1:0] modsub(input logic [N-1:0] x, input logic [N-1:0] y);
    logic signed [N+1:0] d;
    d = $signed({2'b00, x}) - $signed({2'b00, y});
    if (d[N+1]) d = d + $signed({1'b0, QE});
    return N'(d);
  endfunction

  function automatic logic [N-1:0] modmul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
    p = p % QM;
    return N'(p);
  endfunction

  // Q is odd, so an odd residue plus Q is even and the shift is exact
  function automatic logic [N-1:0] modhalve(input logic [N-1:0] x);
    logic [N:0] t;
    t = x[0] ? ({1'b0, x} + QE) : {1'b0, x};
    return N'(t >> 1);
  endfunction

  always_comb begin
    r0 = a;
    r1 = b;
    case (op)
      OP_ADDSUB: begin
        r0 = modadd(a, b);
        r1 = modsub(a, b);
      end
      OP_PASS_MUL: r1 = modmul(b, w);
      OP_HALVE: begin
        r0 = modhalve(a);
        r1 = modhalve(b);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// Three-stage modular butterfly (CT forward / GS inverse, optional halving)
// with a valid/ready handshake and collapsing bubbles.
module ntt_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int Q     = Q_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic             in_halve,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [N-1:0]     in_w,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_x,
  output logic [N-1:0]     out_y,
  output logic [TAG_W-1:0] out_tag
);

  logic             vld_p0, vld_p1, vld_p2;
  logic             mode_p0;
  logic             halve_p0, halve_p1;
  logic [TAG_W-1:0] tag_p0, tag_p1, tag_p2;
  logic [N-1:0]     u_p0, v_p0, w_p0;
  logic [N-1:0]     x_p1, y_p1;
  logic [N-1:0]     x_p2, y_p2;

  logic             en_p1, en_p2;
  logic [1:0]       op_s1, op_s2, op_s3;
  logic [N-1:0]     r0_s1, r1_s1, r0_s2, r1_s2, r0_s3, r1_s3;

  // A stage loads when it is empty or its contents move on this edge
  assign en_p2    = !vld_p2 || out_ready;
  assign en_p1    = !vld_p1 || en_p2;
  assign in_ready = !vld_p0 || en_p1;

  // ---- S1: CT (a, w*b) / GS (a+b, a-b)
  assign op_s1 = (in_mode == MODE_GS) ? OP_ADDSUB : OP_PASS_MUL;

  mod_arith_unit #(.N(N), .Q(Q)) u_au_s1 (
    .op (op_s1),
    .a  (in_a),
    .b  (in_b),
    .w  (in_w),
    .r0 (r0_s1),
    .r1 (r1_s1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
    end else if (in_ready) begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        mode_p0  <= in_mode;
        halve_p0 <= in_halve;
        tag_p0   <= in_tag;
        u_p0     <= r0_s1;
        v_p0     <= r1_s1;
        w_p0     <= in_w;
      end
    end
  end

  // ---- S2: CT (u+v, u-v) / GS (u, v*w)
  assign op_s2 = (mode_p0 == MODE_GS) ? OP_PASS_MUL : OP_ADDSUB;

  mod_arith_unit #(.N(N), .Q(Q)) u_au_s2 (
    .op (op_s2),
    .a  (u_p0),
    .b  (v_p0),
    .w  (w_p0),
    .r0 (r0_s2),
    .r1 (r1_s2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (en_p1) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        halve_p1 <= halve_p0;
        tag_p1   <= tag_p0;
        x_p1     <= r0_s2;
        y_p1     <= r1_s2;
      end
    end
  end

  // ---- S3: optional scaling by 2^-1, drives the outputs
  assign op_s3 = halve_p1 ? OP_HALVE : OP_PASS;

  mod_arith_unit #(.N(N), .Q(Q)) u_au_s3 (
    .op (op_s3),
    .a  (x_p1),
    .b  (y_p1),
    .w  ({N{1'b0}}),
    .r0 (r0_s3),
    .r1 (r1_s3)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      tag_p2 <= '0;
      x_p2   <= '0;
      y_p2   <= '0;
    end else if (en_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        tag_p2 <= tag_p1;
        x_p2   <= r0_s3;
        y_p2   <= r1_s3;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_x     = x_p2;
  assign out_y     = y_p2;
  assign out_tag   = tag_p2;

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Randomized and directed bench for ntt_butterfly_pipe against a plain
// modular-arithmetic reference model with an ordered expectation queue.
module tb_ntt_butterfly_pipe;
  import ntt_pkg::*;

  localparam int N    = N_DEF;
  localparam int Q    = Q_DEF;
  localparam int TW   = TAG_W_DEF;
  localparam int HINV = (Q + 1) / 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_mode, in_halve;
  logic [N-1:0]  in_a, in_b, in_w;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_x, out_y;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  ntt_butterfly_pipe #(.N(N), .Q(Q), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_halve  (in_halve),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_w      (in_w),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_tag   (out_tag)
  );

  int     n_chk   = 0;
  int     n_pass  = 0;
  int     acc_cnt = 0;
  int     rx_cnt  = 0;
  int     cyc     = 0;
  stage_t exp_q[$];
  int     pop_cyc[$];

  task automatic chk_eq(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // Reference: plain integer arithmetic mod Q, halving as multiplication by 2^-1
  function automatic stage_t ref_bfly(input logic mode, input logic halve,
                                      input int a, input int b, input int w,
                                      input int tag);
    stage_t r;
    int x, y, t;
    if (mode == 1'b0) begin
      t = (w * b) % Q;
      x = (a + t) % Q;
      y = (a - t + Q) % Q;
    end else begin
      x = (a + b) % Q;
      y = (((a - b + Q) % Q) * w) % Q;
    end
    if (halve) begin
      x = (x * HINV) % Q;
      y = (y * HINV) % Q;
    end
    r.valid = 1'b1;
    r.mode  = mode_e'(mode);
    r.halve = halve;
    r.tag   = TW'(tag);
    r.p0    = N'(x);
    r.p1    = N'(y);
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: inputs and outputs are stable at the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk_eq("spurious_out", int'(out_valid), 0);
        end else begin
          chk_eq("out_x", int'(out_x), int'(exp_q[0].p0));
          chk_eq("out_y", int'(out_y), int'(exp_q[0].p1));
          chk_eq("out_tag", int'(out_tag), int'(exp_q[0].tag));
          if (out_ready) begin
            void'(exp_q.pop_front());
            rx_cnt++;
            pop_cyc.push_back(cyc);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_bfly(in_mode, in_halve, int'(in_a), int'(in_b),
                                 int'(in_w), int'(in_tag)));
        acc_cnt++;
      end
    end
  end

  task automatic drive(input logic mode, input logic halve, input int a,
                       input int b, input int w, input int tag);
    in_valid = 1'b1;
    in_mode  = mode;
    in_halve = halve;
    in_a     = N'(a);
    in_b     = N'(b);
    in_w     = N'(w);
    in_tag   = TW'(tag);
  endtask

  task automatic drive_rand(input int tag);
    drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
          int'($urandom_range(Q - 1, 0)), int'($urandom_range(Q - 1, 0)),
          int'($urandom_range(Q - 1, 0)), tag);
  endtask

  // Hold the transaction until accepted; returns just after the accept edge
  task automatic send(input logic mode, input logic halve, input int a,
                      input int b, input int w, input int tag);
    int k;
    drive(mode, halve, a, b, w, tag);
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk_eq("send_timeout", k, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < lim) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic directed(input string name, input logic mode, input logic halve,
                          input int a, input int b, input int w, input int tag,
                          input int ex, input int ey);
    int n;
    out_ready = 1'b1;
    send(mode, halve, a, b, w, tag);
    in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_eq({name, "_latency"}, n, 3);
    chk_eq({name, "_x"}, int'(out_x), ex);
    chk_eq({name, "_y"}, int'(out_y), ey);
    chk_eq({name, "_tag"}, int'(out_tag), tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d, want < 20000", cyc);
    $fatal(1);
  end

  initial begin
    int a0, r0, b0, cnt;
    logic rdy;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_halve  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_w      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("rst_out_valid", int'(out_valid), 0);
    chk_eq("rst_in_ready", int'(in_ready), 1);
    chk_eq("rst_out_x", int'(out_x), 0);
    chk_eq("rst_out_y", int'(out_y), 0);
    chk_eq("rst_out_tag", int'(out_tag), 0);
    @(posedge clk);
    #1;

    directed("gs", 1'b1, 1'b0, 5, 10, 3, 8'h11, 15, 242);
    directed("gs_half", 1'b1, 1'b1, 5, 10, 3, 8'h12, 136, 121);
    directed("ct", 1'b0, 1'b0, 10, 5, 3, 8'h21, 25, 252);
    directed("ct_wrap", 1'b0, 1'b0, 256, 256, 256, 8'h22, 0, 255);
    directed("ct_half", 1'b0, 1'b1, 0, 1, 1, 8'h23, 129, 128);
    drain(20);

    // Streaming, mode alternating every cycle
    out_ready = 1'b1;
    b0 = pop_cyc.size();
    for (int i = 0; i < 20; i++)
      send(1'(i % 2), 1'($urandom_range(1, 0)), int'($urandom_range(Q - 1, 0)),
           int'($urandom_range(Q - 1, 0)), int'($urandom_range(Q - 1, 0)), 64 + i);
    drain(40);
    chk_eq("stream_count", pop_cyc.size() - b0, 20);
    if (pop_cyc.size() >= b0 + 20)
      chk_eq("stream_rate", pop_cyc[b0 + 19] - pop_cyc[b0], 19);

    // Back-pressure with continuous input
    out_ready = 1'b0;
    a0 = acc_cnt;
    r0 = rx_cnt;
    drive_rand(128);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) drive_rand(129 + c);
    end
    in_valid = 1'b0;
    chk_eq("bp_accepts", acc_cnt - a0, 3);
    chk_eq("bp_in_ready", int'(in_ready), 0);
    chk_eq("bp_rx_stalled", rx_cnt - r0, 0);
    drain(20);
    chk_eq("bp_rx", rx_cnt - r0, 3);

    // Bubble collapse: S3 held, pulsed inputs fill S2 then S1
    out_ready = 1'b0;
    r0 = rx_cnt;
    send(1'b1, 1'b1, 7, 200, 99, 160);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    a0 = acc_cnt;
    for (int p = 0; p < 4; p++) begin
      drive_rand(170 + p);
      @(negedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    chk_eq("bubble_accepts", acc_cnt - a0, 2);
    chk_eq("bubble_in_ready", int'(in_ready), 0);
    chk_eq("bubble_out_valid", int'(out_valid), 1);
    drain(20);
    chk_eq("bubble_rx", rx_cnt - r0, 3);

    // Reset with two transactions in flight
    out_ready = 1'b1;
    send(1'b0, 1'b0, 1, 2, 3, 200);
    send(1'b1, 1'b1, 4, 5, 6, 201);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("mid_rst_out_valid", int'(out_valid), 0);
    chk_eq("mid_rst_out_x", int'(out_x), 0);
    chk_eq("mid_rst_out_y", int'(out_y), 0);
    chk_eq("mid_rst_out_tag", int'(out_tag), 0);
    chk_eq("mid_rst_in_ready", int'(in_ready), 1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk_eq("stale_after_rst", cnt, 0);

    // Post-reset sanity: pipeline still works
    @(posedge clk);
    #1;
    directed("post_rst", 1'b1, 1'b0, 5, 10, 3, 8'h33, 15, 242);
    drain(20);
    chk_eq("final_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
